aes_byte_stream_adapter: RTL
============================

AES_BYTE_STREAM_ADAPTER -- requirements
Module: aes_byte_stream_adapter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of clock cycles the combinational AES core is given to settle (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have in_byte, input, 8 bits: plaintext byte stream.
REQ-005 SHALL have in_valid (input, 1) and in_ready (output, 1); a byte transfers on a rising edge with both high.
REQ-006 SHALL have key_in (input, 128) and key_load (input, 1): key load request.
REQ-007 SHALL have core_plaintext (output, 128) and core_key (output, 128), both driving the AES core.
REQ-008 SHALL have core_ciphertext, input, 128 bits: the AES core result.
REQ-009 SHALL have out_byte (output, 8), out_valid (output, 1) and out_ready (input, 1); a byte transfers on a rising edge with out_valid and out_ready both high.
REQ-010 SHALL have busy, output, 1 bit: high in SETTLE or DRAIN.
REQ-011 SHALL have block_count, output, 16 bits: number of completed blocks.

Function
REQ-012 SHALL implement a three-state FSM with states FILL, SETTLE and DRAIN.
REQ-013 in_ready SHALL be 1 in FILL and 0 otherwise; it SHALL be decoded from state only.
REQ-014 In FILL, each accepted byte SHALL shift the 128-bit plaintext register left by 8 with in_byte entering bits [7:0].
- The first byte of a block ends in [127:120].
REQ-015 A 4-bit byte counter SHALL increment per accepted byte. On acceptance of byte 16, the counter SHALL clear and the FSM SHALL go to SETTLE.
REQ-016 core_plaintext SHALL be the plaintext register directly, and core_key SHALL be the key register directly.
REQ-017 key_load SHALL latch key_in only when state is FILL and the byte counter is 0; otherwise key_load SHALL be ignored.
- The key is never changed mid-block.
REQ-018 If key_load and an in_byte acceptance coincide at counter 0, both SHALL take effect on the same edge.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES clock cycles. On the last edge it SHALL capture core_ciphertext into the output register and go to DRAIN.
REQ-020 In DRAIN, out_valid SHALL be 1 and out_byte SHALL be output_reg[127-8*idx -: 8], with idx incrementing per transfer.
- Byte 0 is [127:120].
REQ-021 out_byte SHALL hold stable while out_valid=1 and out_ready=0, for any stall length.
REQ-022 On transfer of byte 16, the FSM SHALL return to FILL, idx SHALL clear, and block_count SHALL increment.
- block_count wraps from 0xFFFF to 0x0000.
REQ-023 in_valid SHALL be ignored outside FILL, and out_ready SHALL be ignored outside DRAIN.
REQ-024 Latency: out_valid SHALL first rise immediately after the SETTLE_CYCLES-th rising edge following the edge that accepted byte 16.
REQ-025 The next block's first byte SHALL be acceptable in the cycle after the edge transferring output byte 16.

Reset
REQ-026 While rst=1, the block SHALL immediately set:
- state = FILL
- byte counter, idx and settle counter = 0
- plaintext, key and output registers = 0
- block_count = 0
- out_valid = 0, out_byte = 0x00, busy = 0, in_ready = 1
REQ-027 Reset asserted mid-FILL, mid-SETTLE or mid-DRAIN SHALL discard the partial block without emitting further out_valid. After release, the first accepted byte SHALL be treated as byte 0.

Verification
REQ-028 Key 0 loaded, then 16 bytes 0x00 -> after SETTLE_CYCLES edges, out bytes 66 E9 4B D4 EF 8A 2C 3B 88 4C FA 59 CA 34 2B 2E; block_count=1.
REQ-029 Key 000102030405060708090A0B0C0D0E0F, plaintext bytes 00 11 22 ... FF -> core_plaintext=00112233445566778899AABBCCDDEEFF; output 69 C4 E0 D8 6A 7B 04 30 D8 CD B7 80 70 B4 C5 5A.
REQ-030 out_ready held low for 10 cycles during DRAIN -> out_valid stays 1, out_byte unchanged, in_ready stays 0; drain resumes correctly afterwards.
REQ-031 key_load pulsed at byte counter 7 with a new key -> core_key unchanged and the ciphertext matches the old key; the same pulse at counter 0 of the next block -> the new key is used.
REQ-032 rst pulsed after byte 9 and again during DRAIN byte 5 -> all outputs return to reset values; a subsequent full block yields a correct ciphertext with block_count=1.
REQ-033 Preload block_count to 0xFFFF by running 65535 blocks (or via force) and complete one more block -> block_count=0x0000.

Source files
------------

// File: rtl/aes_byte_stream_adapter.sv
// Byte-stream wrapper around a combinational AES-128 core: gathers 16 plaintext
// bytes, waits for the core to settle, then streams the 16 ciphertext bytes out.
module aes_byte_stream_adapter #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_byte,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic [127:0] core_plaintext,
   output logic [127:0] core_key,
   input  logic [127:0] core_ciphertext,
   output logic [7:0]   out_byte,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic [15:0]  block_count
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SET_W = 8;
   localparam int unsigned BC_W  = 16;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(15);

   typedef enum logic [1:0] {FILL, SETTLE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt_q;
   logic [CNT_W-1:0]   idx_q;
   logic [SET_W-1:0]   settle_q;
   logic [BLK_W-1:0]   pt_q;
   logic [BLK_W-1:0]   key_q;
   logic [BLK_W-1:0]   out_q;
   logic [BC_W-1:0]    blk_cnt_q;
   logic               accept;
   logic               xfer;
   logic               key_en;
   logic               settle_done;
   logic [BLK_W-1:0]   out_shift;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FILL;
      else     state_q <= state_d;
   end

   // Next state and handshake decode, all derived from the current state
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      accept      = 1'b0;
      xfer        = 1'b0;
      key_en      = 1'b0;
      settle_done = 1'b0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            accept   = in_valid;
            key_en   = key_load && (byte_cnt_q == '0);
            if (accept && (byte_cnt_q == CNT_LAST)) state_d = SETTLE;
         end
         SETTLE: begin
            busy        = 1'b1;
            settle_done = (settle_q == SETTLE_LAST);
            if (settle_done) state_d = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            xfer      = out_ready;
            if (xfer && (idx_q == CNT_LAST)) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // Datapath: plaintext shift-in, key latch, settle timer, result capture, drain index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_q <= '0;
         idx_q      <= '0;
         settle_q   <= '0;
         pt_q       <= '0;
         key_q      <= '0;
         out_q      <= '0;
         blk_cnt_q  <= '0;
      end else begin
         if (key_en) key_q <= key_in;
         if (accept) begin
            pt_q       <= {pt_q[BLK_W-9:0], in_byte};
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
         end
         if (state_q == SETTLE) settle_q <= settle_done ? '0 : settle_q + SET_W'(1);
         if (settle_done) out_q <= core_ciphertext;
         if (xfer) begin
            idx_q <= idx_q + CNT_W'(1);
            if (idx_q == CNT_LAST) blk_cnt_q <= blk_cnt_q + BC_W'(1);
         end
      end
   end

   // Output byte selection: byte 0 is the most significant byte
   always_comb begin
      out_shift = out_q << {idx_q, 3'b000};
      out_byte  = out_valid ? out_shift[BLK_W-1 -: 8] : 8'h00;
   end

   assign core_plaintext = pt_q;
   assign core_key       = key_q;
   assign block_count    = blk_cnt_q;

endmodule
